// File: rtl/vga_renderer_if.sv
// Pixel-side bus between the VGA renderer and the snake game core.
//   master (renderer): drives x_out/y_out, hsync/vsync, rgb, frame_tick,
//                      update_tick; receives entity, game_over, game_won.
//   slave  (game core / observer): the mirror image.
interface vga_renderer_if;
   logic [1:0]  entity;
   logic        game_over;
   logic        game_won;
   logic [9:0]  x_out;
   logic [9:0]  y_out;
   logic        hsync;
   logic        vsync;
   logic [11:0] rgb;
   logic        frame_tick;
   logic        update_tick;

   modport master (
      input  entity, game_over, game_won,
      output x_out, y_out, hsync, vsync, rgb, frame_tick, update_tick
   );

   modport slave (
      output entity, game_over, game_won,
      input  x_out, y_out, hsync, vsync, rgb, frame_tick, update_tick
   );
endinterface

// File: rtl/vga_renderer.sv
// VGA timing generator and entity-to-RGB renderer for the snake game.
// Ports:
//   vga_clk  pixel clock
//   rst      asynchronous active-high reset
//   bus      vga_renderer_if.master: coordinates out, entity/flags in,
//            sync/rgb and frame/update ticks out (all registered).
// Pipeline: stage 0 = counters (x_out/y_out), stage 1 = active/sync decode,
// stage 2 = hsync/vsync/rgb. The game core answers a coordinate one clock
// later, so its entity code lines up with stage 1.
module vga_renderer #(
   parameter int unsigned H_VISIBLE     = 640,
   parameter int unsigned H_FP          = 16,
   parameter int unsigned H_SYNC        = 96,
   parameter int unsigned H_BP          = 48,
   parameter int unsigned V_VISIBLE     = 480,
   parameter int unsigned V_FP          = 10,
   parameter int unsigned V_SYNC        = 2,
   parameter int unsigned V_BP          = 33,
   parameter int unsigned UPDATE_FRAMES = 8
) (
   input  logic           vga_clk,
   input  logic           rst,
   vga_renderer_if.master bus
);

   localparam int unsigned CNT_W    = 10;
   localparam int unsigned H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_START = H_VISIBLE + H_FP;
   localparam int unsigned HS_END   = HS_START + H_SYNC;
   localparam int unsigned VS_START = V_VISIBLE + V_FP;
   localparam int unsigned VS_END   = VS_START + V_SYNC;
   localparam int unsigned FC_W     = (UPDATE_FRAMES > 1) ? $clog2(UPDATE_FRAMES) : 1;

   logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
   logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
   logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;
   logic             active_q, hs_raw_q, vs_raw_q;
   logic             hsync_q, vsync_q;
   logic [11:0]      rgb_q;
   logic             frame_tick_q, update_tick_q;

   logic             line_end_c, frame_end_c, last_step_c;
   logic [11:0]      colour_c;

   // Next-state for the raster counters and the frame divider.
   always_comb begin
      line_end_c  = (h_cnt_q == CNT_W'(H_TOTAL - 1));
      frame_end_c = line_end_c && (v_cnt_q == CNT_W'(V_TOTAL - 1));
      last_step_c = (frame_cnt_q == FC_W'(UPDATE_FRAMES - 1));

      h_cnt_d     = h_cnt_q + CNT_W'(1);
      v_cnt_d     = v_cnt_q;
      frame_cnt_d = frame_cnt_q;

      if (line_end_c) begin
         h_cnt_d = '0;
         v_cnt_d = frame_end_c ? '0 : v_cnt_q + CNT_W'(1);
      end

      if (frame_end_c) begin
         frame_cnt_d = last_step_c ? '0 : frame_cnt_q + FC_W'(1);
      end
   end

   // Entity colour map; the empty-cell background signals the game result.
   always_comb begin
      colour_c = 12'h000;
      if (active_q) begin
         unique case (bus.entity)
            2'b00:   colour_c = 12'hF00;
            2'b01:   colour_c = 12'h0F0;
            2'b10:   colour_c = 12'h080;
            default: begin
               if (bus.game_won)       colour_c = 12'h004;
               else if (bus.game_over) colour_c = 12'h400;
               else                    colour_c = 12'h000;
            end
         endcase
      end
   end

   // Counters, two-stage sync/colour pipeline and tick generation.
   always_ff @(posedge vga_clk or posedge rst) begin
      if (rst) begin
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         frame_cnt_q   <= '0;
         active_q      <= 1'b0;
         hs_raw_q      <= 1'b1;
         vs_raw_q      <= 1'b1;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         rgb_q         <= 12'h000;
         frame_tick_q  <= 1'b0;
         update_tick_q <= 1'b0;
      end else begin
         h_cnt_q     <= h_cnt_d;
         v_cnt_q     <= v_cnt_d;
         frame_cnt_q <= frame_cnt_d;

         active_q <= (h_cnt_q < CNT_W'(H_VISIBLE)) && (v_cnt_q < CNT_W'(V_VISIBLE));
         hs_raw_q <= !((h_cnt_q >= CNT_W'(HS_START)) && (h_cnt_q < CNT_W'(HS_END)));
         vs_raw_q <= !((v_cnt_q >= CNT_W'(VS_START)) && (v_cnt_q < CNT_W'(VS_END)));

         hsync_q <= hs_raw_q;
         vsync_q <= vs_raw_q;
         rgb_q   <= colour_c;

         // Decoded on the last clock of the frame, visible on the first of the next.
         frame_tick_q  <= frame_end_c;
         update_tick_q <= frame_end_c && last_step_c;
      end
   end

   assign bus.x_out       = h_cnt_q;
   assign bus.y_out       = v_cnt_q;
   assign bus.hsync       = hsync_q;
   assign bus.vsync       = vsync_q;
   assign bus.rgb         = rgb_q;
   assign bus.frame_tick  = frame_tick_q;
   assign bus.update_tick = update_tick_q;

endmodule
